muldiv_sequencer: RTL



---
 rtl/muldiv_sequencer_pkg.sv | 41 ++++
 rtl/muldiv_sequencer_if.sv | 26 ++
 rtl/muldiv_negate.sv | 14 +
 rtl/muldiv_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared defines for the RV32M multiply/divide sequencer: funct7/funct3 codes,
// sequencer state encodings and operand-signedness helpers.
package muldiv_sequencer_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic is_muldiv(input logic [6:0] funct7);
        return funct7 == FUNCT7_MULDIV;
    endfunction

    function automatic logic is_div_op(input funct3_e f);
        return f[2];
    endfunction

    function automatic logic a_is_signed(input funct3_e f);
        return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic b_is_signed(input funct3_e f);
        return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> muldiv sequencer request/result bundle.
interface muldiv_sequencer_if #(
    parameter int unsigned XLEN = 32
);

    logic            i_start;
    logic            i_flush;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_a;
    logic [XLEN-1:0] i_b;
    logic            o_stall;
    logic            o_busy;
    logic            o_done;
    logic [XLEN-1:0] o_result;

    modport master (
        output i_start, i_flush, i_funct3, i_a, i_b,
        input  o_stall, o_busy, o_done, o_result
    );

    modport slave (
        input  i_start, i_flush, i_funct3, i_a, i_b,
        output o_stall, o_busy, o_done, o_result
    );

endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement of a W-bit value.
module muldiv_negate #(
    parameter int unsigned W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    always_comb begin
        o_val = i_neg ? (~i_val + W'(1)) : i_val;
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M sequencer: shift-add multiply / restoring divide, one step per
// cycle over XLEN cycles, with sign fix-up and divide-by-zero/overflow fast path.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_sequencer_if.slave   bus
);

    localparam int unsigned     CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    funct3_e           funct3_q, funct3_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    funct3_e           req_f3;
    logic              a_neg, b_neg, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN:0]     mul_sum, div_trial, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next;

    assign req_f3  = funct3_e'(bus.i_funct3);
    assign a_neg   = a_is_signed(req_f3) & bus.i_a[XLEN-1];
    assign b_neg   = b_is_signed(req_f3) & bus.i_b[XLEN-1];
    assign div_ovf = ((req_f3 == F3_DIV) || (req_f3 == F3_REM))
                     && (bus.i_a == MIN_NEG) && (bus.i_b == '1);

    muldiv_negate #(.W(XLEN))   u_neg_a    (.i_neg(a_neg),     .i_val(bus.i_a),                .o_val(a_mag));
    muldiv_negate #(.W(XLEN))   u_neg_b    (.i_neg(b_neg),     .i_val(bus.i_b),                .o_val(b_mag));
    muldiv_negate #(.W(2*XLEN)) u_neg_prod (.i_neg(neg_res_q), .i_val(acc_q),                  .o_val(prod_fix));
    muldiv_negate #(.W(XLEN))   u_neg_quo  (.i_neg(neg_res_q), .i_val(acc_q[XLEN-1:0]),        .o_val(quo_fix));
    muldiv_negate #(.W(XLEN))   u_neg_rem  (.i_neg(neg_rem_q), .i_val(acc_q[2*XLEN-1:XLEN]),   .o_val(rem_fix));

    // acc holds {product_hi, product_lo} for multiply and {remainder, quotient} for divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_trial = acc_q[2*XLEN-1:XLEN-1];
        div_diff  = div_trial - {1'b0, opnd_q};
        if (div_diff[XLEN]) begin
            div_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start && !bus.i_flush) begin
                    funct3_d  = req_f3;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = CW'(XLEN - 1);
                    state_d   = S_RUN;
                    if (is_div_op(req_f3)) begin
                        opnd_d = b_mag;
                        acc_d  = {{XLEN{1'b0}}, a_mag};
                        if (bus.i_b == '0) begin
                            state_d  = S_DONE;
                            result_d = req_f3[1] ? bus.i_a : '1;
                        end else if (div_ovf) begin
                            state_d  = S_DONE;
                            result_d = req_f3[1] ? '0 : bus.i_a;
                        end
                    end else begin
                        opnd_d = a_mag;
                        acc_d  = {{XLEN{1'b0}}, b_mag};
                    end
                end
            end
            S_RUN: begin
                if (bus.i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_op(funct3_q) ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            S_FIX: begin
                if (bus.i_flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (is_div_op(funct3_q)) begin
                        result_d = funct3_q[1] ? rem_fix : quo_fix;
                    end else if (funct3_q == F3_MUL) begin
                        result_d = prod_fix[XLEN-1:0];
                    end else begin
                        result_d = prod_fix[2*XLEN-1:XLEN];
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            funct3_q  <= F3_MUL;
            opnd_q    <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign bus.o_stall  = ((state_q == S_IDLE) && bus.i_start && !bus.i_flush)
                          || (state_q == S_RUN) || (state_q == S_FIX);
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;
    assign bus.o_result = result_q;

endmodule
